// File: rtl/z80_alu_imm_exec.sv
// z80_alu_imm_exec: fetch/execute/retire sequencer for the 8-bit ALU-immediate group (op A,n).
// Emits one z80fi retirement record per completed instruction.
module z80_alu_imm_exec #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [7:0]  load_a,
    input  logic [7:0]  load_f,
    input  logic [15:0] load_ip,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_f,
    output logic [15:0] reg_ip,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        illegal,
    output logic        timeout,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [7:0]  z80fi_reg_a_in,
    output logic [7:0]  z80fi_reg_a_out,
    output logic [7:0]  z80fi_reg_f_in,
    output logic [7:0]  z80fi_reg_f_out,
    output logic [15:0] z80fi_reg_ip_in,
    output logic [15:0] z80fi_reg_ip_out
);
    localparam logic [2:0] S_IDLE = 3'd0, S_FOP = 3'd1, S_FN = 3'd2, S_EXEC = 3'd3, S_RET = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  a_q, a_d, f_q, f_d, op_q, op_d, n_q, n_d;
    logic [15:0] ip_q, ip_d, cnt_q, cnt_d;
    logic        ill_q, ill_d, to_q, to_d;
    logic [31:0] insn_q, insn_d;
    logic [2:0]  len_q, len_d;
    logic [7:0]  ai_q, ai_d, ao_q, ao_d, fi_q, fi_d, fo_q, fo_d;
    logic [15:0] ipi_q, ipi_d, ipo_q, ipo_d;

    logic [2:0] alu_op;
    logic       is_sub, is_log, cin, ov, h, to_hit;
    logic [8:0] sum9, dif9;
    logic [4:0] hs5, hd5;
    logic [7:0] log_r, res, a_new, f_new;

    always_comb begin
        alu_op = op_q[5:3];
        is_sub = (alu_op == 3'd2) || (alu_op == 3'd3) || (alu_op == 3'd7);
        is_log = (alu_op == 3'd4) || (alu_op == 3'd5) || (alu_op == 3'd6);
        cin    = ((alu_op == 3'd1) || (alu_op == 3'd3)) && f_q[0];
        sum9   = {1'b0, a_q} + {1'b0, n_q} + {8'd0, cin};
        dif9   = {1'b0, a_q} - {1'b0, n_q} - {8'd0, cin};
        hs5    = {1'b0, a_q[3:0]} + {1'b0, n_q[3:0]} + {4'd0, cin};
        hd5    = {1'b0, a_q[3:0]} - {1'b0, n_q[3:0]} - {4'd0, cin};
        log_r  = (alu_op == 3'd4) ? (a_q & n_q) : (alu_op == 3'd5) ? (a_q ^ n_q) : (a_q | n_q);
        res    = is_log ? log_r : is_sub ? dif9[7:0] : sum9[7:0];
        ov     = is_sub ? ((a_q[7] != n_q[7]) && (res[7] != a_q[7])) : ((a_q[7] == n_q[7]) && (res[7] != a_q[7]));
        h      = (alu_op == 3'd4) ? 1'b1 : is_log ? 1'b0 : is_sub ? hd5[4] : hs5[4];
        // Bits 5 and 3 pass through from the incoming F rather than from the result.
        f_new  = {res[7], res == 8'd0, f_q[5], h, f_q[3], is_log ? ~^res : ov, is_sub,
                  is_log ? 1'b0 : is_sub ? dif9[8] : sum9[8]};
        a_new  = (alu_op == 3'd7) ? a_q : res;
        to_hit = (MEM_TIMEOUT != 0) && (cnt_q == 16'(MEM_TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d = a_q; f_d = f_q; ip_d = ip_q; op_d = op_q; n_d = n_q;
        cnt_d = cnt_q + 16'd1;
        ill_d = 1'b0; to_d = 1'b0;
        insn_d = insn_q; len_d = len_q;
        ai_d = ai_q; ao_d = ao_q; fi_d = fi_q; fo_d = fo_q; ipi_d = ipi_q; ipo_d = ipo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (load) begin
                    a_d = load_a; f_d = load_f; ip_d = load_ip;
                end else if (start) state_d = S_FOP;
            end
            S_FOP: begin
                if (mem_ack) begin
                    op_d = mem_rdata;
                    cnt_d = 16'd0;
                    ill_d = !(mem_rdata[7:6] == 2'b11 && mem_rdata[2:0] == 3'b110);
                    state_d = ill_d ? S_IDLE : S_FN;
                end else if (to_hit) begin
                    to_d = 1'b1; state_d = S_IDLE;
                end
            end
            S_FN: begin
                if (mem_ack) begin
                    n_d = mem_rdata; state_d = S_EXEC;
                end else if (to_hit) begin
                    to_d = 1'b1; state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                a_d = a_new; f_d = f_new; ip_d = ip_q + 16'd2;
                insn_d = {16'h0, n_q, op_q}; len_d = 3'd2;
                ai_d = a_q; ao_d = a_new; fi_d = f_q; fo_d = f_new; ipi_d = ip_q; ipo_d = ip_q + 16'd2;
                state_d = S_RET;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q <= '0; f_q <= '0; ip_q <= '0; op_q <= '0; n_q <= '0; cnt_q <= '0;
            ill_q <= 1'b0; to_q <= 1'b0; insn_q <= '0; len_q <= '0;
            ai_q <= '0; ao_q <= '0; fi_q <= '0; fo_q <= '0; ipi_q <= '0; ipo_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d; f_q <= f_d; ip_q <= ip_d; op_q <= op_d; n_q <= n_d; cnt_q <= cnt_d;
            ill_q <= ill_d; to_q <= to_d; insn_q <= insn_d; len_q <= len_d;
            ai_q <= ai_d; ao_q <= ao_d; fi_q <= fi_d; fo_q <= fo_d; ipi_q <= ipi_d; ipo_q <= ipo_d;
        end
    end

    assign busy             = state_q != S_IDLE;
    assign reg_a            = a_q;
    assign reg_f            = f_q;
    assign reg_ip           = ip_q;
    assign mem_req          = (state_q == S_FOP) || (state_q == S_FN);
    assign mem_addr         = (state_q == S_FN) ? ip_q + 16'd1 : (state_q == S_FOP) ? ip_q : 16'd0;
    assign illegal          = ill_q;
    assign timeout          = to_q;
    assign z80fi_valid      = state_q == S_RET;
    assign z80fi_insn       = insn_q;
    assign z80fi_insn_len   = len_q;
    assign z80fi_reg_a_in   = ai_q;
    assign z80fi_reg_a_out  = ao_q;
    assign z80fi_reg_f_in   = fi_q;
    assign z80fi_reg_f_out  = fo_q;
    assign z80fi_reg_ip_in  = ipi_q;
    assign z80fi_reg_ip_out = ipo_q;
endmodule

// File: doc/z80_alu_imm_exec.md
Name: z80_alu_imm_exec

Overview:
Execution-side sequencer for the 8-bit ALU-immediate group (ADD/ADC/SUB/SBC/AND/XOR/OR/CP A,n; opcode 11ooo110, 2 bytes).
- Fetches opcode and immediate from memory over a req/ack handshake.
- Updates its internal A, F and IP registers.
- Emits one z80fi retirement record per instruction for the formal spec checker to consume.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles for mem_ack before abort (0 = wait forever).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  when idle, load A/F/IP from load_a/load_f/load_ip.
- load_a  in  8  A load value.
- load_f  in  8  F load value.
- load_ip  in  16  IP load value.
- start  in  1  begin one instruction at IP (sampled only in IDLE).
- busy  out  1  high in any state other than IDLE.
- reg_a  out  8  current A.
- reg_f  out  8  current F.
- reg_ip  out  16  current IP.
- mem_req  out  1  read request.
- mem_addr  out  16  read address.
- mem_ack  in  1  read data valid.
- mem_rdata  in  8  read data.
- illegal  out  1  one-cycle pulse: fetched opcode not 11???110.
- timeout  out  1  one-cycle pulse: fetch aborted.
- z80fi_valid  out  1  one-cycle retirement strobe.
- z80fi_insn  out  32  {16'h0, n, opcode}.
- z80fi_insn_len  out  3  always 2 when valid.
- z80fi_reg_a_in  out  8  pre-instruction A.
- z80fi_reg_a_out  out  8  post-instruction A.
- z80fi_reg_f_in  out  8  pre-instruction F.
- z80fi_reg_f_out  out  8  post-instruction F.
- z80fi_reg_ip_in  out  16  pre-instruction IP.
- z80fi_reg_ip_out  out  16  post-instruction IP.

Behaviour:
- Reset: all outputs and registers 0; state IDLE.
- Reset asserted mid-instruction aborts it: no retirement, no pulse.
- States:
  - IDLE: load has priority over start. On start: latch A/F/IP as *_in snapshots, go FETCH_OP.
  - FETCH_OP: mem_req=1, mem_addr=IP. Hold until mem_ack, latch opcode.
    - Opcode not 11???110: pulse illegal, registers unchanged, go IDLE.
    - Otherwise go FETCH_N.
  - FETCH_N: mem_req=1, mem_addr=IP+1 (16-bit wrap: FFFF -> 0000). On mem_ack latch n, go EXEC.
  - EXEC: compute the result, write A/F, IP += 2 (16-bit wrap), go RETIRE.
  - RETIRE: z80fi_valid=1 for exactly this cycle, all z80fi_* stable. Then IDLE.
- mem_req is deasserted in the cycle after ack.
- mem_rdata is sampled only when mem_ack=1.
- Acks outside FETCH_OP/FETCH_N are ignored.
- Timeout: counter reset on entering each fetch state. After MEM_TIMEOUT cycles without ack: pulse timeout, abort to IDLE, registers unchanged.
- Latency with ack in the same cycle as req: start -> z80fi_valid = 4 cycles.
- Arithmetic, op = opcode[5:3]: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
  - cin = F.C for ADC/SBC, else 0.
  - Result is 8 bits, mod 256.
  - CP computes A-n for flags but leaves A unchanged.
- Flags, F = {S,Z,5,H,3,PV,N,C}:
  - S = result[7]; Z = (result==0).
  - Bits 5 and 3 are copied from F_in.
  - H: AND -> 1; XOR/OR -> 0; add -> carry out of bit 3; sub/CP -> borrow into bit 4.
  - PV: logical ops -> even parity of result; arithmetic -> signed overflow.
  - N = 1 for SUB/SBC/CP.
  - C: logical ops -> 0; add -> carry out of bit 7; sub -> borrow.
- z80fi outputs hold their last values between strobes.

Test Plan:
- Load A=7F F=00 IP=0100, mem[0100..0101]=C6 01 (ADD 1) -> valid after 4 cycles. a_out=80, f_out=94, ip_out=0102, insn=000001C6, len=2.
- A=10 F=00, D6 01 (SUB 1) -> A=0F, F=12. A=10, FE 10 (CP 10) -> A stays 10, F=42.
- A=FF F=01, CE 00 (ADC 0) -> A=00, F=51. A=F0 F=28, E6 0F (AND) -> A=00, F=7C (bits 5/3 kept).
- IP=FFFF, C6 01 -> second fetch addr 0000, ip_out=0001. Opcode 3E -> illegal pulse, IP unchanged, no z80fi_valid.
- Ack withheld 15 cycles in FETCH_N -> timeout pulse, A/F/IP unchanged. Ack delayed 5 cycles -> normal retire.
- reset_n low during FETCH_N -> all outputs 0 immediately, no valid. load and start together -> load wins, busy stays 0.
